// File: rtl/pipe_if_stage.sv
// rtl/pipe_if_stage.sv - instruction fetch stage with IF/ID register, req/ack imem and buffered redirect
module pipe_if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wpcir,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] rpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] dpc4,
    output logic [31:0] dinst,
    output logic        dvalid,
    output logic        if_busy
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] dpc4_q, dpc4_d;
    logic [31:0] dinst_q, dinst_d;
    logic        dvalid_q, dvalid_d;
    logic        pend_v_q, pend_v_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic [31:0] skid_q, skid_d;

    logic [31:0] pc4;
    logic [31:0] sel_tgt;
    logic [31:0] npc;

    always_comb begin
        pc4     = pc_q + 32'd4;
        sel_tgt = pc4;
        case (pcsource)
            2'b01:   sel_tgt = bpc;
            2'b10:   sel_tgt = jpc;
            2'b11:   sel_tgt = rpc;
            default: sel_tgt = pc4;
        endcase
        // A redirect captured during a stalled fetch wins over whatever ID presents now.
        npc = pend_v_q ? pend_tgt_q : sel_tgt;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        dpc4_d     = dpc4_q;
        dinst_d    = dinst_q;
        dvalid_d   = dvalid_q;
        pend_v_d   = pend_v_q;
        pend_tgt_d = pend_tgt_q;
        skid_d     = skid_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    if (wpcir) begin
                        dpc4_d   = pc4;
                        dinst_d  = imem_rdata;
                        dvalid_d = 1'b1;
                        pc_d     = npc;
                        pend_v_d = 1'b0;
                    end else begin
                        skid_d  = imem_rdata;
                        state_d = S_HOLD;
                    end
                end else if (wpcir) begin
                    dinst_d  = 32'h0;
                    dvalid_d = 1'b0;
                    if (pcsource != 2'b00) begin
                        pend_tgt_d = sel_tgt;
                        pend_v_d   = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (wpcir) begin
                    dpc4_d   = pc4;
                    dinst_d  = skid_q;
                    dvalid_d = 1'b1;
                    pc_d     = npc;
                    pend_v_d = 1'b0;
                    state_d  = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            dpc4_q     <= 32'h0;
            dinst_q    <= 32'h0;
            dvalid_q   <= 1'b0;
            pend_v_q   <= 1'b0;
            pend_tgt_q <= 32'h0;
            skid_q     <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            dpc4_q     <= dpc4_d;
            dinst_q    <= dinst_d;
            dvalid_q   <= dvalid_d;
            pend_v_q   <= pend_v_d;
            pend_tgt_q <= pend_tgt_d;
            skid_q     <= skid_d;
        end
    end

    assign imem_req  = (state_q == S_FETCH) && !reset;
    assign imem_addr = pc_q;
    assign dpc4      = dpc4_q;
    assign dinst     = dinst_q;
    assign dvalid    = dvalid_q;
    assign if_busy   = (state_q == S_FETCH) && !imem_ack;

endmodule
